// File: rtl/disp_axil_pkg.sv
// disp_axil_pkg
// Shared types and helpers for the Pong display AXI4-Lite register file:
// response encoding, register indices, write/read FSM state enums and the
// byte-strobe merge used when committing a write.
package disp_axil_pkg;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;

  // Register indices as selected by address bits [3:2]
  localparam logic [1:0] REG_PADDLE_L = 2'd0;
  localparam logic [1:0] REG_PADDLE_R = 2'd1;
  localparam logic [1:0] REG_BALL_XY  = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Bytes whose strobe bit is set take the new value, all others keep the old one
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/disp_axil_regs_wr_ch.sv
// disp_axil_wr_ch
// AXI4-Lite write channel: accepts AW and W in either order (or together),
// holds whichever beat arrives first, and emits a single-cycle commit with
// the register index, data and strobe once both beats are in. BVALID is
// raised on the edge that completes the final handshake and held until BREADY.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   aw_idx, aw_valid, aw_ready        write address (register index only)
//   w_data, w_strb, w_valid, w_ready  write data channel
//   b_valid, b_ready                  write response handshake
//   commit, commit_idx/data/strb      register update request (same cycle as
//                                     the final handshake)
module disp_axil_wr_ch
  import disp_axil_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      aw_idx,
  input  logic            aw_valid,
  output logic            aw_ready,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_strb,
  input  logic            w_valid,
  output logic            w_ready,
  output logic            b_valid,
  input  logic            b_ready,
  output logic            commit,
  output logic [1:0]      commit_idx,
  output logic [DW-1:0]   commit_data,
  output logic [DW/8-1:0] commit_strb
);

  wr_state_t state, next_state;

  // Keeps the ready outputs low while reset is asserted and for the first
  // edge after release, so nothing is accepted before the block is live.
  logic live;

  logic [1:0]      idx_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;

  logic aw_hs, w_hs;
  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= W_IDLE;
      live  <= 1'b0;
    end else begin
      state <= next_state;
      live  <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) next_state = W_RESP;
        else if (aw_hs)    next_state = W_WAIT_W;
        else if (w_hs)     next_state = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_hs)    next_state = W_RESP;
      W_WAIT_AW: if (aw_hs)   next_state = W_RESP;
      W_RESP:    if (b_ready) next_state = W_IDLE;
      default:   next_state = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = live && (state == W_IDLE || state == W_WAIT_AW);
    w_ready  = live && (state == W_IDLE || state == W_WAIT_W);
    b_valid  = (state == W_RESP);
  end

  // Whichever beat arrives first is held here until its partner shows up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) idx_q <= aw_idx;
      if (w_hs) begin
        data_q <= w_data;
        strb_q <= w_strb;
      end
    end
  end

  // The live channel supplies its half of the commit; the held half comes
  // from the latches when the beats arrived on different cycles.
  always_comb begin
    commit      = 1'b0;
    commit_idx  = aw_idx;
    commit_data = w_data;
    commit_strb = w_strb;
    case (state)
      W_IDLE:   commit = aw_hs && w_hs;
      W_WAIT_W: begin
        commit     = w_hs;
        commit_idx = idx_q;
      end
      W_WAIT_AW: begin
        commit      = aw_hs;
        commit_data = data_q;
        commit_strb = strb_q;
      end
      default: commit = 1'b0;
    endcase
  end

endmodule

// File: rtl/disp_axil_regs.sv
// disp_axil_regs
// AXI4-Lite register file for the Pong display driver. Four 32-bit registers
// (left paddle Y, right paddle Y, ball X/Y, control) are written and read over
// S00_AXI with OKAY-only, fixed-latency responses and presented as flat
// outputs to the pixel generator.
// Optional feature, macro DISP_FRAME_LATCH_EN: when defined, the four outputs
// come from shadow registers reloaded on the edge where vsync is high, so
// the picture only changes at frame start. When undefined, outputs follow
// the live registers and vsync is unused.
// Ports:
//   S_AXI_*       AXI4-Lite slave interface (AWPROT/ARPROT ignored)
//   vsync         one-cycle frame-start pulse
//   paddle_l_y    REG0 (0x0), paddle_r_y REG1 (0x4), ball_xy REG2 (0x8),
//   ctrl          REG3 (0xC)
//   reg_wr_pulse  one-hot per register, high the cycle after a write commit
module disp_axil_regs
  import disp_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_CTRL         = 32'h0000_0000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              vsync,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     paddle_l_y,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     paddle_r_y,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ball_xy,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  wire clk   = S_AXI_ACLK;
  wire rst_n = S_AXI_ARESETN;

  logic [DW-1:0] regs [4];

  logic            commit;
  logic [1:0]      commit_idx;
  logic [DW-1:0]   commit_data;
  logic [DW/8-1:0] commit_strb;

  disp_axil_wr_ch #(.DW(DW)) u_wr_ch (
    .clk         (clk),
    .rst_n       (rst_n),
    .aw_idx      (S_AXI_AWADDR[3:2]),
    .aw_valid    (S_AXI_AWVALID),
    .aw_ready    (S_AXI_AWREADY),
    .w_data      (S_AXI_WDATA),
    .w_strb      (S_AXI_WSTRB),
    .w_valid     (S_AXI_WVALID),
    .w_ready     (S_AXI_WREADY),
    .b_valid     (S_AXI_BVALID),
    .b_ready     (S_AXI_BREADY),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[REG_PADDLE_L] <= '0;
      regs[REG_PADDLE_R] <= '0;
      regs[REG_BALL_XY]  <= '0;
      regs[REG_CTRL]     <= RESET_CTRL;
    end else if (commit) begin
      regs[commit_idx] <= apply_wstrb(regs[commit_idx], commit_data, commit_strb);
    end
  end

  // Pulse fires even for an all-zero strobe: the write still happened
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_wr_pulse <= '0;
    else        reg_wr_pulse <= commit ? (4'b0001 << commit_idx) : 4'b0000;
  end

  rd_state_t rd_state, rd_next;
  logic      rd_live;
  logic      ar_hs;

  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_live  <= 1'b0;
    end else begin
      rd_state <= rd_next;
      rd_live  <= 1'b1;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)        rd_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = rd_live && (rd_state == R_IDLE);
    S_AXI_RVALID  = (rd_state == R_DATA);
  end

  // Sampled with non-blocking semantics, so a read captured on the same edge
  // as a write commit to that register returns the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     S_AXI_RDATA <= '0;
    else if (ar_hs) S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
  end

`ifdef DISP_FRAME_LATCH_EN
  logic [DW-1:0] shadow [4];

  // A write committing on the vsync edge lands in regs but not in the
  // shadow, so it shows up at the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow[REG_PADDLE_L] <= '0;
      shadow[REG_PADDLE_R] <= '0;
      shadow[REG_BALL_XY]  <= '0;
      shadow[REG_CTRL]     <= RESET_CTRL;
    end else if (vsync) begin
      for (int i = 0; i < 4; i++) shadow[i] <= regs[i];
    end
  end

  assign paddle_l_y = shadow[REG_PADDLE_L];
  assign paddle_r_y = shadow[REG_PADDLE_R];
  assign ball_xy    = shadow[REG_BALL_XY];
  assign ctrl       = shadow[REG_CTRL];

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
`else
  assign paddle_l_y = regs[REG_PADDLE_L];
  assign paddle_r_y = regs[REG_PADDLE_R];
  assign ball_xy    = regs[REG_BALL_XY];
  assign ctrl       = regs[REG_CTRL];

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, vsync};
`endif

endmodule

// File: doc/disp_axil_regs.md
Name: disp_axil_regs

Overview:
- AXI4-Lite responder (slave) register file for the Pong display driver IP.
- Sits behind the PS/VIP master on the S00_AXI port.
- Holds four 32-bit control registers (left paddle Y, right paddle Y, ball X/Y, control/score) and presents them as flat outputs to the pixel-generation logic.
- Answers every AXI4-Lite write and read with a fixed-latency, OKAY-only response.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- RESET_CTRL, 32'h0000_0000, reset value of REG3 (control).

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response, always 2'b00
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  4  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always 2'b00
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- vsync  in  1  frame-start pulse from the display timing block, one cycle, S_AXI_ACLK domain
- paddle_l_y  out  32  REG0 at byte offset 0x0
- paddle_r_y  out  32  REG1 at byte offset 0x4
- ball_xy  out  32  REG2 at byte offset 0x8
- ctrl  out  32  REG3 at byte offset 0xC
- reg_wr_pulse  out  4  one-hot, one cycle, high when the matching register is written

Behaviour:
- Reset: asynchronous assert on ARESETN low; release is sampled on the clock.
  - REG0..REG2 reset to 0; REG3 resets to RESET_CTRL.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, reg_wr_pulse, RDATA all reset to 0.
  - A reset in mid-transaction abandons the transaction and emits no response.
- Write FSM states: W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
  - W_IDLE: AWREADY=1 and WREADY=1.
  - AW and W in the same cycle: commit the write, go to W_RESP.
  - Only AW handshakes: latch the address, go to W_WAIT_W with AWREADY=0.
  - Only W handshakes: latch data and strobe, go to W_WAIT_AW with WREADY=0.
  - From W_WAIT_W or W_WAIT_AW, the missing beat completes the write and the FSM goes to W_RESP.
  - Commit: each byte whose WSTRB bit is set is updated; WSTRB=0 is still OKAY with no register change.
  - reg_wr_pulse[idx] is high in the cycle after commit, even when WSTRB=0.
  - W_RESP: BVALID=1, AWREADY=0, WREADY=0. BVALID holds until BREADY, then the FSM returns to W_IDLE.
  - BVALID rises on the edge after the final handshake: 1-cycle latency from the last handshake.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On handshake, register RDATA from REG[ARADDR[3:2]] and go to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA stays stable until RREADY, then the FSM returns to R_IDLE.
  - Read latency is 1 cycle after the AR handshake.
- Read and write FSMs are independent.
  - Read captured on the same edge as a write commit to the same register returns the old value.
- Throughput: at most one write per 2 cycles and one read per 2 cycles.
- Outputs paddle_l_y..ctrl follow live REG values, subject to the optional feature.

Optional Feature:
- Macro: DISP_FRAME_LATCH_EN.
- Defined:
  - The four outputs come from shadow registers loaded from REG0..REG3 only in the cycle after vsync=1.
  - Shadows reset to the same values as the REGs.
  - AXI reads return the live REG values, not the shadows.
  - A write committed in the same cycle as vsync is visible in the shadow at the next vsync.
- Undefined: outputs are driven combinationally from the live REGs and vsync is unused.

Decomposition:
- Package disp_axil_pkg:
  - typedef resp_t and constant RESP_OKAY=2'b00.
  - register index constants REG_PADDLE_L=0 .. REG_CTRL=3.
  - enums for the write and read FSM states.
  - byte-strobe merge function apply_wstrb(old, new, strb).
- Sub-module disp_axil_wr_ch contains the write FSM and the address/data latches; reads, registers and shadows stay in the top level.

Test Plan:
- Write 1, 2, 3, 4 to offsets 0x0, 0x4, 0x8, 0xC, then read all four -> RDATA 1, 2, 3, 4, all BRESP and RRESP = 0, outputs match.
- AW presented 3 cycles before W to 0x8, data 0xDEADBEEF -> AWREADY falls after the AW handshake, BVALID 1 cycle after the W handshake, ball_xy = 0xDEADBEEF. Repeat with W before AW -> same result.
- REG1 = 0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> readback 0xFF34FF78; reg_wr_pulse = 4'b0010 for exactly 1 cycle.
- Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and RDATA stable; no new AW, W or AR accepted until the handshakes complete.
- Assert ARESETN low during W_WAIT_W -> BVALID stays 0, all registers 0 (ctrl = RESET_CTRL); next transaction completes normally.
- DISP_FRAME_LATCH_EN defined: write 0x55 to 0x0 -> paddle_l_y unchanged and read returns 0x55 until a vsync pulse; after vsync, paddle_l_y = 0x55 on the following cycle.
